// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce scanner and its compact-target expander.
package miner_pkg;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        CHECK
    } scan_state_t;

    // Expand a compact difficulty word (exponent byte + 23-bit mantissa + sign) to a 256-bit target.
    function automatic logic [HASH_W-1:0] compact_to_target(input logic [31:0] i_bits);
        logic [HASH_W-1:0] mant;
        logic [HASH_W-1:0] tgt;
        int unsigned       e;
        mant = {{(HASH_W-23){1'b0}}, i_bits[22:0]};
        e    = 32'(i_bits[31:24]);
        if (i_bits[23] || (i_bits[22:0] == 23'd0)) begin
            tgt = '0;
        end else if (e <= 3) begin
            tgt = mant >> (8 * (3 - e));
        end else if (e <= 32) begin
            tgt = mant << (8 * (e - 3));
        end else begin
            tgt = '1;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/nonce_scanner_if.sv
// Miner start/done handshake: the scanner is the master, the miner the slave.
interface nonce_scanner_if;
    import miner_pkg::*;

    logic               miner_reset;
    logic               miner_start;
    logic [NONCE_W-1:0] miner_nonce;
    logic               miner_done;
    logic [HASH_W-1:0]  miner_hash;

    modport master (
        output miner_reset,
        output miner_start,
        output miner_nonce,
        input  miner_done,
        input  miner_hash
    );

    modport slave (
        input  miner_reset,
        input  miner_start,
        input  miner_nonce,
        output miner_done,
        output miner_hash
    );

endinterface

// File: rtl/nbits_to_target.sv
// Combinational compact-bits to 256-bit target expansion.
module nbits_to_target
    import miner_pkg::*;
(
    input  logic [31:0]       i_bits,
    output logic [HASH_W-1:0] o_target
);

    assign o_target = compact_to_target(i_bits);

endmodule

// File: rtl/nonce_scanner.sv
// Nonce range scanner driving one miner per attempt and comparing its hash
// against the expanded difficulty target.
// Optional build macro NONCE_SCANNER_STATS_EN adds a saturating attempts counter output.
module nonce_scanner
    import miner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int TIMEOUT_W      = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_start,
    input  logic               scan_stop,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic [31:0]        bits,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash,
    output logic               exhausted,
    output logic               timeout_err,
    nonce_scanner_if.master    mif
`ifdef NONCE_SCANNER_STATS_EN
    ,
    output logic [31:0]        attempts
`endif
);

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    scan_state_t        r_state;
    scan_state_t        w_next;
    logic [NONCE_W-1:0] r_cur_nonce;
    logic [NONCE_W-1:0] r_end_nonce;
    logic [HASH_W-1:0]  r_target;
    logic [HASH_W-1:0]  r_hash;
    logic [HASH_W-1:0]  w_target;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic               r_found;
    logic               r_exhausted;
    logic               r_timeout;
    logic [NONCE_W-1:0] r_found_nonce;
    logic [HASH_W-1:0]  r_found_hash;
    logic               w_accept;
    logic               w_set_found;
    logic               w_set_exh;
    logic               w_set_to;
    logic               w_advance;
    logic               w_win;

    nbits_to_target u_nbits (
        .i_bits   (bits),
        .o_target (w_target)
    );

    assign w_win = (r_hash <= r_target);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; scan_stop overrides any result arriving in the same cycle.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_set_found = 1'b0;
        w_set_exh   = 1'b0;
        w_set_to    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (scan_start) begin
                    w_accept = 1'b1;
                    w_next   = CLEAR;
                end
            end
            CLEAR: begin
                w_next = scan_stop ? IDLE : RUN;
            end
            RUN: begin
                if (scan_stop) begin
                    w_next = IDLE;
                end else if (mif.miner_done) begin
                    w_next = CHECK;
                end else if (r_wdog == WDOG_LAST) begin
                    w_set_to = 1'b1;
                    w_next   = IDLE;
                end
            end
            CHECK: begin
                if (scan_stop) begin
                    w_next = IDLE;
                end else if (w_win) begin
                    w_set_found = 1'b1;
                    w_next      = IDLE;
                end else if (r_cur_nonce == r_end_nonce) begin
                    w_set_exh = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_advance = 1'b1;
                    w_next    = CLEAR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Scan datapath: range/target latch, nonce advance, hash capture, watchdog and sticky results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_nonce   <= '0;
            r_end_nonce   <= '0;
            r_target      <= '0;
            r_hash        <= '0;
            r_wdog        <= '0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_timeout     <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
        end else begin
            if (w_accept) begin
                r_cur_nonce <= nonce_first;
                r_end_nonce <= nonce_last;
                r_target    <= w_target;
                r_found     <= 1'b0;
                r_exhausted <= 1'b0;
                r_timeout   <= 1'b0;
            end
            if (w_advance) begin
                r_cur_nonce <= r_cur_nonce + 32'd1;
            end
            if ((r_state == RUN) && mif.miner_done) begin
                r_hash <= mif.miner_hash;
            end
            if (r_state == RUN) begin
                r_wdog <= r_wdog + TIMEOUT_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_set_found) begin
                r_found       <= 1'b1;
                r_found_nonce <= r_cur_nonce;
                r_found_hash  <= r_hash;
            end
            if (w_set_exh) begin
                r_exhausted <= 1'b1;
            end
            if (w_set_to) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef NONCE_SCANNER_STATS_EN
    logic [31:0] r_attempts;

    // Count CHECK entries since the last accepted start, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_attempts <= '0;
        end else if (w_accept) begin
            r_attempts <= '0;
        end else if ((r_state == RUN) && (w_next == CHECK) && (r_attempts != '1)) begin
            r_attempts <= r_attempts + 32'd1;
        end
    end

    assign attempts = r_attempts;
`endif

    assign busy            = (r_state != IDLE);
    assign found           = r_found;
    assign found_nonce     = r_found_nonce;
    assign found_hash      = r_found_hash;
    assign exhausted       = r_exhausted;
    assign timeout_err     = r_timeout;
    assign mif.miner_reset = (r_state == IDLE) || (r_state == CLEAR);
    assign mif.miner_start = (r_state == RUN);
    assign mif.miner_nonce = r_cur_nonce;

endmodule

// File: doc/nonce_scanner.md
Name: nonce_scanner

Overview:
Controller on the initiator side of the miner start/done handshake. It sweeps a nonce range and drives one miner instance per attempt. For each attempt it expands the compact `bits` field to a 256-bit target and compares the miner's big-endian hash against it. It reports the first winning nonce, or range exhaustion. Header fields other than nonce go straight from the parent to the miner; the parent holds them stable while `busy`=1.

Parameters:
TIMEOUT_CYCLES, 2048, max cycles in RUN awaiting miner_done before timeout_err
TIMEOUT_W, 12, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
scan_start  in  1  pulse; latch range/bits and begin scanning (ignored while busy)
scan_stop  in  1  pulse; abort scan
nonce_first  in  32  first nonce tried
nonce_last  in  32  last nonce tried, inclusive
bits  in  32  compact difficulty target
busy  out  1  scan in progress
found  out  1  sticky; winning nonce found
found_nonce  out  32  winning nonce
found_hash  out  256  winning hash, big-endian numeric
exhausted  out  1  sticky; range finished with no winner
timeout_err  out  1  sticky; miner failed to finish
miner_reset  out  1  synchronous reset to the miner
miner_start  out  1  level start to the miner
miner_nonce  out  32  nonce presented to the miner
miner_done  in  1  miner result valid; stays high until miner_reset
miner_hash  in  256  miner output hash, MSB = most-significant numeric byte

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy/found/exhausted/timeout_err=0; found_nonce=0; found_hash=0; miner_start=0; miner_nonce=0.
  - miner_reset=1.
- IDLE: miner_reset=1, miner_start=0.
  - On scan_start: latch nonce_first→cur_nonce, nonce_last→end_nonce, and target=expand(bits).
  - Clear found/exhausted/timeout_err; busy=1; go to CLEAR.
- CLEAR (1 cycle): miner_reset=1, miner_nonce=cur_nonce; go to RUN.
- RUN: miner_reset=0, miner_start=1; watchdog counts up.
  - On miner_done=1: register miner_hash→hash_q, miner_start=0, go to CHECK.
  - If watchdog reaches TIMEOUT_CYCLES first: timeout_err=1, go to IDLE.
- CHECK (1 cycle): win when hash_q <= target, unsigned 256-bit.
  - Win: found=1, found_nonce=cur_nonce, found_hash=hash_q, go to IDLE.
  - Miss, cur_nonce==end_nonce: exhausted=1, go to IDLE.
  - Otherwise: cur_nonce += 1 (mod 2^32), go to CLEAR.
- busy=1 in CLEAR/RUN/CHECK; it falls in the same cycle that found, exhausted or timeout_err rises.
- Per-attempt latency = 1 (CLEAR) + miner latency + 1 (CHECK).
- Compact expansion, with exp=bits[31:24] and mant={bits[22:0]}:
  - bits[23]=1 (negative) or mant==0: target=0.
  - exp<=3: target = mant >> 8*(3-exp).
  - 3<exp<=32: target = mant << 8*(exp-3), truncated to 256 bits.
  - exp>32: target = all ones.
- Range wrap: if nonce_first > nonce_last, the nonce counts through 0xFFFFFFFF→0.
  - nonce_last = nonce_first-1 sweeps all 2^32 values.
  - nonce_first==nonce_last makes exactly one attempt.
- scan_stop in any busy state: go to IDLE with no sticky flag set; miner_reset=1 next cycle.
  - scan_stop in the same cycle as miner_done or CHECK: stop wins, result discarded.
- scan_start while busy is ignored. scan_start together with scan_stop in IDLE: start wins.
- found/exhausted/timeout_err stay set until the next accepted scan_start or reset.

Optional Feature:
NONCE_SCANNER_STATS_EN:
- Defined: adds output attempts [31:0]. It clears on accepted scan_start, increments on every CHECK entry, and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- miner_pkg holds:
  - constants NONCE_W=32, HASH_W=256;
  - scan_state_t enum {IDLE, CLEAR, RUN, CHECK};
  - function compact_to_target(bits)→256-bit.
- One sub-module, nbits_to_target: combinational compact expansion. Its output is registered once in nonce_scanner at scan_start.

Test Plan:
- Genesis header with a behavioural miner model, bits=0x1d00ffff, nonce 0x7c2bac1b..0x7c2bac1f → found=1 after 3 attempts; found_nonce=0x7c2bac1d; found_hash=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
- Same header, range 0x00000000..0x00000003 with model hashes all > target → exhausted=1 after 4 attempts, found=0.
- Wrap case: nonce_first=0xFFFFFFFE, nonce_last=0x00000001, model wins only at 0x00000000 → found_nonce=0x00000000 after 3 attempts.
- Expansion vectors: bits=0x1d00ffff→0x00000000ffff followed by 26 zero bytes; 0x03123456→0x123456; 0x01123456→0x12; 0x04923456→0; 0x21010000→all ones.
- Model miner never asserts done → timeout_err=1 exactly TIMEOUT_CYCLES after RUN entry; busy=0. Also: scan_stop coincident with miner_done on a winning hash → found=0, busy=0.
- reset_n dropped mid-RUN → all outputs at reset values asynchronously, miner_reset=1. After release, scan_start runs normally from nonce_first.
